alu_md: RTL

Parametrised multi-cycle multiply/divide unit executing the RV32M operations alongside the single-cycle ALU in the execute stage. Takes operands through a valid/ready handshake and computes multiplies in one registered cycle. Computes divides/remainders with a restoring shift-subtract iteration, one quotient bit per clock. Holds its result until the consumer accepts it; the pipeline stalls on `Busy`.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_md_div_step.sv | 23 ++
 rtl/alu_md.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide unit.
package alu_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT    = 32;
  localparam int unsigned MD_CTRL_WIDTH_DEFAULT = 3;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  localparam logic [DATA_WIDTH_DEFAULT-1:0] MOST_NEG_DEFAULT =
    {1'b1, {(DATA_WIDTH_DEFAULT-1){1'b0}}};
  localparam logic [DATA_WIDTH_DEFAULT-1:0] ALL_ONES_DEFAULT = '1;

endpackage

// File: rtl/alu_md_div_step.sv
// One restoring division iteration: shift in the next dividend bit, trial-subtract.
module div_step
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic [DATA_WIDTH-1:0] i_rem,
  input  logic [DATA_WIDTH-1:0] i_quo,
  input  logic [DATA_WIDTH-1:0] i_dvs,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic [DATA_WIDTH-1:0] o_quo
);

  logic [DATA_WIDTH:0] w_shift;
  logic [DATA_WIDTH:0] w_diff;

  // The extra top bit of the difference is the borrow: set means the trial failed.
  assign w_shift = {i_rem, i_quo[DATA_WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_dvs};
  assign o_rem   = w_diff[DATA_WIDTH] ? w_shift[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];
  assign o_quo   = {i_quo[DATA_WIDTH-2:0], ~w_diff[DATA_WIDTH]};

endmodule

// File: rtl/alu_md.sv
// RV32M multiply/divide unit: one-cycle multiply, bit-serial restoring divide,
// valid/ready on both sides with the result held until accepted.
module alu_md
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int unsigned MD_CTRL_WIDTH = MD_CTRL_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MD_CTRL_WIDTH-1:0] MDControl,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic [DATA_WIDTH-1:0]    Result,
  output logic                     Zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     Busy
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [DATA_WIDTH-1:0] L_ALL_ONES = '1;
  localparam logic [DATA_WIDTH-1:0] L_MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  md_state_e             r_state;
  md_op_e                r_op;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_quo;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_out_valid;
  logic                  r_busy;
  logic                  r_in_ready;

  md_op_e                  w_op;
  logic                    w_b_zero;
  logic                    w_ovf;
  logic                    w_a_neg;
  logic                    w_b_neg;
  logic [DATA_WIDTH-1:0]   w_a_mag;
  logic [DATA_WIDTH-1:0]   w_b_mag;
  logic [DATA_WIDTH-1:0]   w_special_res;
  logic                    w_a_sx;
  logic                    w_b_sx;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0]   w_mul_res;
  logic [DATA_WIDTH-1:0]   w_rem_nx;
  logic [DATA_WIDTH-1:0]   w_quo_nx;
  logic [DATA_WIDTH-1:0]   w_q_fin;
  logic [DATA_WIDTH-1:0]   w_r_fin;
  logic [DATA_WIDTH-1:0]   w_div_res;

  // Accept-time decode; op[0] clear on a divide op means signed.
  assign w_op     = md_op_e'(MDControl[2:0]);
  assign w_b_zero = (SrcB == '0);
  assign w_ovf    = !w_op[0] && (SrcA == L_MOST_NEG) && (SrcB == L_ALL_ONES);
  assign w_a_neg  = !w_op[0] && SrcA[DATA_WIDTH-1];
  assign w_b_neg  = !w_op[0] && SrcB[DATA_WIDTH-1];
  assign w_a_mag  = w_a_neg ? -SrcA : SrcA;
  assign w_b_mag  = w_b_neg ? -SrcB : SrcB;

  always_comb begin
    w_special_res = '0;
    if (w_b_zero) begin
      w_special_res = w_op[1] ? SrcA : L_ALL_ONES;
    end else begin
      w_special_res = w_op[1] ? '0 : L_MOST_NEG;
    end
  end

  // Sign-extending both operands to 2W bits gives every signedness mix from one multiplier.
  assign w_a_sx    = ((r_op == MD_MULH) || (r_op == MD_MULHSU)) && r_a[DATA_WIDTH-1];
  assign w_b_sx    = (r_op == MD_MULH) && r_b[DATA_WIDTH-1];
  assign w_prod    = {{DATA_WIDTH{w_a_sx}}, r_a} * {{DATA_WIDTH{w_b_sx}}, r_b};
  assign w_mul_res = (r_op == MD_MUL) ? w_prod[DATA_WIDTH-1:0]
                                      : w_prod[2*DATA_WIDTH-1:DATA_WIDTH];

  div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_div_step (
    .i_rem(r_rem),
    .i_quo(r_quo),
    .i_dvs(r_b),
    .o_rem(w_rem_nx),
    .o_quo(w_quo_nx)
  );

  assign w_q_fin   = r_neg_q ? -r_quo : r_quo;
  assign w_r_fin   = r_neg_r ? -r_rem : r_rem;
  assign w_div_res = r_op[1] ? w_r_fin : w_q_fin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= MD_MUL;
      r_a         <= '0;
      r_b         <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op       <= w_op;
            r_a        <= SrcA;
            r_b        <= w_op[2] ? w_b_mag : SrcB;
            r_quo      <= w_a_mag;
            r_rem      <= '0;
            r_neg_q    <= !w_op[1] && (w_a_neg ^ w_b_neg);
            r_neg_r    <= w_op[1] && w_a_neg;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (!w_op[2]) begin
              r_state <= ST_MUL;
            end else if (w_b_zero || w_ovf) begin
              r_result    <= w_special_res;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_cnt   <= CNT_W'(DATA_WIDTH);
              r_state <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          r_result    <= w_mul_res;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DIV: begin
          // Counter at zero marks the sign-correction cycle after the last step.
          if (r_cnt != '0) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_result    <= w_div_res;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Result    = r_result;
  assign Zero      = (r_result == '0);
  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
  assign Busy      = r_busy;

endmodule
